// File: rtl/cond_pkg.sv
// Shared types and constants for the input conditioner: the debounce state
// encoding and the width/ceiling of the optional glitch counter.
package cond_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } cond_state_t;

    localparam int             COND_GLITCH_W   = 8;
    localparam logic [7:0]     COND_GLITCH_MAX = 8'd255;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser that brings an asynchronous bit into the clock domain.
// Cleared asynchronously by active-low clearb; STAGES must be 2 or more.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic clearb,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronise, debounce and edge-detect a raw asynchronous input.
// Optional macro INPUT_CONDITIONER_GLITCH_COUNT_EN adds a saturating glitch_count output.
module input_conditioner
    import cond_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 3
) (
    input  logic clock,
    input  logic clearb,
    input  logic noisy_in,
    input  logic enable,
    output logic clean_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
    ,
    output logic [COND_GLITCH_W-1:0] glitch_count
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 s;
    cond_state_t          state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 clean_q, clean_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .clearb(clearb),
        .d_i   (noisy_in),
        .q_o   (s)
    );

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Counter starts at 1 on entry to CHECK, so the last qualifying edge sees CNT_LAST.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            IDLE_LOW: begin
                if (s && enable) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
            CHECK_HIGH: begin
                if (!enable || !s) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                    clean_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s && enable) begin
                    state_d = CHECK_LOW;
                    cnt_d   = CNT_WIDTH'(1);
                end
            end
            CHECK_LOW: begin
                if (!enable || s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                    clean_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign clean_out  = clean_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign busy       = (state_q == CHECK_HIGH) || (state_q == CHECK_LOW);

`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
    logic                     glitch_hit;
    logic [COND_GLITCH_W-1:0] glitch_q;

    // Only aborts caused by the input reverting count; enable-driven aborts do not.
    assign glitch_hit = enable &&
                        (((state_q == CHECK_HIGH) && !s) ||
                         ((state_q == CHECK_LOW)  &&  s));

    always_ff @(posedge clock or negedge clearb) begin
        if (!clearb) begin
            glitch_q <= '0;
        end else if (glitch_hit && (glitch_q != COND_GLITCH_MAX)) begin
            glitch_q <= glitch_q + 1'b1;
        end
    end

    assign glitch_count = glitch_q;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner at default parameters.
// Define INPUT_CONDITIONER_GLITCH_COUNT_EN to also exercise glitch_count.
module tb_input_conditioner;

    typedef struct {
        logic       n;
        logic       e;
        logic [3:0] exp;
    } vec_t;

    logic clock    = 1'b0;
    logic clearb   = 1'b1;
    logic noisy_in = 1'b0;
    logic enable   = 1'b0;
    logic clean_out, rise_pulse, fall_pulse, busy;
`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
    logic [7:0] glitch_count;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[27];

    input_conditioner dut (
        .clock     (clock),
        .clearb    (clearb),
        .noisy_in  (noisy_in),
        .enable    (enable),
        .clean_out (clean_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
        ,
        .glitch_count(glitch_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic n, input logic e);
        noisy_in = n;
        enable   = e;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {4'b0000, clean_out, rise_pulse, fall_pulse, busy};
    endfunction

    // After reset release with noisy_in high: exactly one rise, at the 6th edge.
    task automatic releaseCheck(input string tag);
        int rises = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            rises += int'(rise_pulse);
            if (i == 5)  checkOutput({tag, "_cnt3"},  outs(), 8'b0000_0001);
            if (i == 6)  checkOutput({tag, "_rise"},  outs(), 8'b0000_1100);
            if (i == 10) checkOutput({tag, "_level"}, outs(), 8'b0000_1000);
        end
        checkOutput({tag, "_rise_count"}, 8'(rises), 8'd1);
    endtask

    task automatic bringLow(input string tag);
        applyStimulus(1'b0, 1'b1);
        repeat (5) step();
        checkOutput({tag, "_checklow"}, outs(), 8'b0000_1001);
        step();
        checkOutput({tag, "_fall"}, outs(), 8'b0000_0010);
        step();
        checkOutput({tag, "_low"}, outs(), 8'b0000_0000);
    endtask

    initial begin
        // Rows: inputs applied before an edge, {clean,rise,fall,busy} expected after it.
        vecs[0]  = '{1'b1, 1'b1, 4'b0000};
        vecs[1]  = '{1'b1, 1'b1, 4'b0000};
        vecs[2]  = '{1'b1, 1'b1, 4'b0001};
        vecs[3]  = '{1'b1, 1'b1, 4'b0001};
        vecs[4]  = '{1'b1, 1'b1, 4'b0001};
        vecs[5]  = '{1'b1, 1'b1, 4'b1100};
        vecs[6]  = '{1'b1, 1'b1, 4'b1000};
        vecs[7]  = '{1'b0, 1'b1, 4'b1000};
        vecs[8]  = '{1'b0, 1'b1, 4'b1000};
        vecs[9]  = '{1'b0, 1'b1, 4'b1001};
        vecs[10] = '{1'b0, 1'b1, 4'b1001};
        vecs[11] = '{1'b0, 1'b1, 4'b1001};
        vecs[12] = '{1'b0, 1'b1, 4'b0010};
        vecs[13] = '{1'b0, 1'b1, 4'b0000};
        vecs[14] = '{1'b1, 1'b1, 4'b0000};
        vecs[15] = '{1'b1, 1'b1, 4'b0000};
        vecs[16] = '{1'b1, 1'b1, 4'b0001};
        vecs[17] = '{1'b0, 1'b1, 4'b0001};
        vecs[18] = '{1'b0, 1'b1, 4'b0001};
        vecs[19] = '{1'b0, 1'b1, 4'b0000};
        vecs[20] = '{1'b0, 1'b1, 4'b0000};
        for (int i = 21; i < 27; i++) vecs[i] = '{1'b1, 1'b0, 4'b0000};

        // Reset held with noisy_in high, then release.
        #2 clearb = 1'b0;
        applyStimulus(1'b1, 1'b1);
        step();
        checkOutput("reset_outputs", outs(), 8'b0000_0000);
`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
        checkOutput("reset_glitch", glitch_count, 8'd0);
`endif
        step();
        clearb = 1'b1;
        releaseCheck("release");
        bringLow("low1");

        for (int i = 0; i < 27; i++) begin
            applyStimulus(vecs[i].n, vecs[i].e);
            step();
            checkOutput($sformatf("vec%0d", i), outs(), {4'b0000, vecs[i].exp});
        end
`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
        checkOutput("glitch_one", glitch_count, 8'd1);
`endif

        // Enable dropped at counter 2, then a full restart of qualification.
        applyStimulus(1'b1, 1'b1);
        step();
        checkOutput("gate_cnt1", outs(), 8'b0000_0001);
        step();
        checkOutput("gate_cnt2", outs(), 8'b0000_0001);
        applyStimulus(1'b1, 1'b0);
        step();
        checkOutput("gate_abort", outs(), 8'b0000_0000);
        repeat (3) step();
        checkOutput("gate_hold", outs(), 8'b0000_0000);
        applyStimulus(1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step();
            checkOutput($sformatf("gate_re%0d", i), outs(), 8'b0000_0001);
        end
        step();
        checkOutput("gate_rise", outs(), 8'b0000_1100);
`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
        checkOutput("gate_glitch", glitch_count, 8'd1);
`endif
        bringLow("low2");

        // Asynchronous reset between edges while the counter is at 3.
        applyStimulus(1'b1, 1'b1);
        repeat (5) step();
        checkOutput("mid_cnt3", outs(), 8'b0000_0001);
        #3 clearb = 1'b0;
        #1;
        checkOutput("async_clear", outs(), 8'b0000_0000);
`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
        checkOutput("async_glitch", glitch_count, 8'd0);
`endif
        step();
        step();
        clearb = 1'b1;
        releaseCheck("rerelease");
        bringLow("low3");

`ifdef INPUT_CONDITIONER_GLITCH_COUNT_EN
        begin
            logic cleanSeen = 1'b0;
            for (int g = 0; g < 300; g++) begin
                applyStimulus(1'b1, 1'b1);
                repeat (2) begin step(); cleanSeen |= clean_out; end
                applyStimulus(1'b0, 1'b1);
                repeat (4) begin step(); cleanSeen |= clean_out; end
                if (g == 9) checkOutput("sat_ten", glitch_count, 8'd10);
            end
            checkOutput("sat_count", glitch_count, 8'd255);
            checkOutput("sat_clean", 8'(cleanSeen), 8'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
